reg_file: RTL and testbench

REG_FILE -- requirements
Module: reg_file

---
 rtl/reg_file_pkg.sv | 15 +
 rtl/reg_file_scoreboard.sv | 54 +++++
 rtl/reg_file.sv | 94 +++++++++
 tb/tb_reg_file.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared pipeline constants for the register file and its scoreboard.
// Holds the default data width, the register index width, the hard-wired
// zero register index and the bit positions inside the WB control pair.
package reg_file_pkg;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned REG_IDX_W  = 5;

    localparam logic [REG_IDX_W-1:0] ZERO_REG = '0;

    // WB control pair bit positions
    localparam int unsigned REGWRITE = 0;
    localparam int unsigned MEMTOREG = 1;

endpackage

// File: rtl/reg_file_scoreboard.sv
// reg_scoreboard: one busy bit per architectural register.
// A set marks a register as having an outstanding producer; a clear retires
// it on writeback. Set wins over clear on the same index so a newer producer
// issued on the writeback edge stays tracked. Register 0 is never busy.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   set_en, set_idx    mark set_idx busy at next edge
//   clr_en, clr_idx    clear busy[clr_idx] at next edge
//   rd_a_idx, rd_b_idx lookup indices
//   busy_a, busy_b     raw busy bits for the lookup indices
module reg_scoreboard
    import reg_file_pkg::*;
#(
    parameter int unsigned NUM_REGS = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 set_en,
    input  logic [REG_IDX_W-1:0] set_idx,
    input  logic                 clr_en,
    input  logic [REG_IDX_W-1:0] clr_idx,
    input  logic [REG_IDX_W-1:0] rd_a_idx,
    input  logic [REG_IDX_W-1:0] rd_b_idx,
    output logic                 busy_a,
    output logic                 busy_b
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    always_comb begin
        busy_d = busy_q;
        if (clr_en) begin
            busy_d[clr_idx] = 1'b0;
        end
        // Applied after the clear so that set wins on a collision.
        if (set_en) begin
            busy_d[set_idx] = 1'b1;
        end
        busy_d[ZERO_REG] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_a = busy_q[rd_a_idx];
    assign busy_b = busy_q[rd_b_idx];

endmodule

// File: rtl/reg_file.sv
// reg_file: architectural register file with write-before-read bypass and a
// busy scoreboard that raises hazard_stall while a source awaits writeback.
// Ports:
//   clk, rst_n                          clock, asynchronous active-low reset
//   wb_reg_write, wb_write_reg, wb_data writeback port
//   id_rs, id_rt                        decode source indices
//   rs_data, rt_data                    combinational read data (bypassed)
//   issue_valid, issue_rd               decode issue of a register producer
//   rs_busy, rt_busy, hazard_stall      dependency status of the sources
module reg_file
#(
    parameter int unsigned DATA_WIDTH = reg_file_pkg::DATA_WIDTH,
    parameter int unsigned NUM_REGS   = 32
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              wb_reg_write,
    input  logic [reg_file_pkg::REG_IDX_W-1:0] wb_write_reg,
    input  logic [DATA_WIDTH-1:0]             wb_data,
    input  logic [reg_file_pkg::REG_IDX_W-1:0] id_rs,
    input  logic [reg_file_pkg::REG_IDX_W-1:0] id_rt,
    output logic [DATA_WIDTH-1:0]             rs_data,
    output logic [DATA_WIDTH-1:0]             rt_data,
    input  logic                              issue_valid,
    input  logic [reg_file_pkg::REG_IDX_W-1:0] issue_rd,
    output logic                              rs_busy,
    output logic                              rt_busy,
    output logic                              hazard_stall
);
    import reg_file_pkg::*;

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

    logic wb_hit;
    logic rs_hit;
    logic rt_hit;
    logic eff_issue;
    logic sb_busy_rs;
    logic sb_busy_rt;

    assign wb_hit = wb_reg_write && (wb_write_reg != ZERO_REG);
    assign rs_hit = wb_hit && (wb_write_reg == id_rs);
    assign rt_hit = wb_hit && (wb_write_reg == id_rt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wb_hit) begin
            regs_q[wb_write_reg] <= wb_data;
        end
    end

    // Register 0 is forced to zero on the read side; a same-cycle writeback
    // is forwarded so decode sees the value being retired this cycle.
    always_comb begin
        rs_data = '0;
        if (id_rs != ZERO_REG) begin
            rs_data = rs_hit ? wb_data : regs_q[id_rs];
        end
    end

    always_comb begin
        rt_data = '0;
        if (id_rt != ZERO_REG) begin
            rt_data = rt_hit ? wb_data : regs_q[id_rt];
        end
    end

    // A source retiring this cycle is already satisfied by the bypass.
    assign rs_busy      = sb_busy_rs && !rs_hit && (id_rs != ZERO_REG);
    assign rt_busy      = sb_busy_rt && !rt_hit && (id_rt != ZERO_REG);
    assign hazard_stall = rs_busy || rt_busy;

    // Stalled issues are dropped so the scoreboard only tracks real producers.
    assign eff_issue = issue_valid && !hazard_stall && (issue_rd != ZERO_REG);

    reg_scoreboard #(
        .NUM_REGS (NUM_REGS)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (eff_issue),
        .set_idx  (issue_rd),
        .clr_en   (wb_hit),
        .clr_idx  (wb_write_reg),
        .rd_a_idx (id_rs),
        .rd_b_idx (id_rt),
        .busy_a   (sb_busy_rs),
        .busy_b   (sb_busy_rt)
    );

endmodule

// File: tb/tb_reg_file.sv
module tb_reg_file;

    logic        clk;
    logic        rst_n;
    logic        wb_reg_write;
    logic [4:0]  wb_write_reg;
    logic [31:0] wb_data;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        rs_busy;
    logic        rt_busy;
    logic        hazard_stall;

    reg_file #(
        .DATA_WIDTH (32),
        .NUM_REGS   (32)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wb_reg_write (wb_reg_write),
        .wb_write_reg (wb_write_reg),
        .wb_data      (wb_data),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .rs_data      (rs_data),
        .rt_data      (rt_data),
        .issue_valid  (issue_valid),
        .issue_rd     (issue_rd),
        .rs_busy      (rs_busy),
        .rt_busy      (rt_busy),
        .hazard_stall (hazard_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_pass;

    typedef struct {
        logic        we;
        logic [4:0]  wr;
        logic [31:0] wd;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        iv;
        logic [4:0]  ird;
        logic [31:0] ers;
        logic [31:0] ert;
        logic        erb;
        logic        etb;
        logic        est;
    } vec_t;

    vec_t vecs [15];

    // Reference state: plain arrays of values and outstanding-producer flags.
    logic [31:0] m_regs [32];
    bit          m_busy [32];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic drive(input logic we, input logic [4:0] wr, input logic [31:0] wd,
                         input logic [4:0] rs, input logic [4:0] rt,
                         input logic iv, input logic [4:0] ird);
        wb_reg_write = we;
        wb_write_reg = wr;
        wb_data      = wd;
        id_rs        = rs;
        id_rt        = rt;
        issue_valid  = iv;
        issue_rd     = ird;
    endtask

    task automatic check_all(input string tag, input logic [31:0] ers, input logic [31:0] ert,
                             input logic erb, input logic etb, input logic est);
        check({tag, ".rs_data"}, rs_data, ers);
        check({tag, ".rt_data"}, rt_data, ert);
        check({tag, ".rs_busy"}, {31'd0, rs_busy}, {31'd0, erb});
        check({tag, ".rt_busy"}, {31'd0, rt_busy}, {31'd0, etb});
        check({tag, ".stall"}, {31'd0, hazard_stall}, {31'd0, est});
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        model_reset();

        //          we    wr     wd            rs     rt     iv    ird    ers           ert           rb    tb    st
        vecs[0]  = '{1'b0, 5'd0, 32'h0,        5'd5,  5'd0,  1'b0, 5'd0,  32'h0,        32'h0,        1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 5'd3, 32'hAAAAAAAA, 5'd3,  5'd0,  1'b0, 5'd0,  32'hAAAAAAAA, 32'h0,        1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 5'd0, 32'h0,        5'd3,  5'd0,  1'b0, 5'd0,  32'hAAAAAAAA, 32'h0,        1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 5'd0, 32'h55555555, 5'd0,  5'd3,  1'b0, 5'd0,  32'h0,        32'hAAAAAAAA, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 5'd0, 32'h0,        5'd0,  5'd0,  1'b0, 5'd0,  32'h0,        32'h0,        1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 5'd0, 32'h0,        5'd0,  5'd0,  1'b1, 5'd7,  32'h0,        32'h0,        1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 5'd0, 32'h0,        5'd0,  5'd7,  1'b1, 5'd8,  32'h0,        32'h0,        1'b0, 1'b1, 1'b1};
        vecs[7]  = '{1'b0, 5'd0, 32'h0,        5'd8,  5'd7,  1'b0, 5'd0,  32'h0,        32'h0,        1'b0, 1'b1, 1'b1};
        vecs[8]  = '{1'b1, 5'd7, 32'h12345678, 5'd0,  5'd7,  1'b0, 5'd0,  32'h0,        32'h12345678, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 5'd0, 32'h0,        5'd0,  5'd7,  1'b0, 5'd0,  32'h0,        32'h12345678, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 5'd9, 32'h11,       5'd9,  5'd0,  1'b1, 5'd9,  32'h11,       32'h0,        1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 5'd0, 32'h0,        5'd9,  5'd0,  1'b0, 5'd0,  32'h11,       32'h0,        1'b1, 1'b0, 1'b1};
        vecs[12] = '{1'b1, 5'd5, 32'h33,       5'd9,  5'd5,  1'b0, 5'd0,  32'h11,       32'h33,       1'b1, 1'b0, 1'b1};
        vecs[13] = '{1'b1, 5'd9, 32'h22,       5'd5,  5'd9,  1'b0, 5'd0,  32'h33,       32'h22,       1'b0, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 5'd0, 32'h0,        5'd9,  5'd5,  1'b0, 5'd0,  32'h22,       32'h33,       1'b0, 1'b0, 1'b0};

        rst_n = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd0, 1'b0, 5'd0);
        repeat (2) @(posedge clk);
        #1;
        check_all("in_reset", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // Directed table: each entry is one cycle, checked before its edge.
        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].we, vecs[i].wr, vecs[i].wd, vecs[i].rs, vecs[i].rt,
                  vecs[i].iv, vecs[i].ird);
            #2;
            check_all($sformatf("vec%0d", i), vecs[i].ers, vecs[i].ert,
                      vecs[i].erb, vecs[i].etb, vecs[i].est);
            @(posedge clk);
            #1;
        end

        // Load state, then pull reset low mid-cycle.
        drive(1'b1, 5'd6, 32'h0000DEAD, 5'd0, 5'd0, 1'b1, 5'd4);
        @(posedge clk);
        #1;
        drive(1'b0, 5'd0, 32'h0, 5'd6, 5'd4, 1'b0, 5'd0);
        #1;
        check_all("pre_rst", 32'h0000DEAD, 32'h0, 1'b0, 1'b1, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        check_all("async_rst", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        // Writes and issues presented while held in reset are discarded.
        drive(1'b1, 5'd6, 32'h0000BEEF, 5'd0, 5'd0, 1'b1, 5'd6);
        @(posedge clk);
        #1;
        drive(1'b0, 5'd0, 32'h0, 5'd6, 5'd4, 1'b0, 5'd0);
        #1;
        check_all("held_rst", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        // First edge after release performs normal write and issue.
        drive(1'b1, 5'd6, 32'h00000077, 5'd0, 5'd0, 1'b1, 5'd10);
        @(posedge clk);
        #1;
        drive(1'b0, 5'd0, 32'h0, 5'd6, 5'd10, 1'b0, 5'd0);
        #1;
        check_all("post_rst", 32'h00000077, 32'h0, 1'b0, 1'b1, 1'b1);
        model_reset();
        m_regs[6]  = 32'h00000077;
        m_busy[10] = 1'b1;
        @(posedge clk);
        #1;

        // Randomized traffic against the reference model; small index range
        // forces frequent read/write/issue collisions.
        for (int c = 0; c < 400; c++) begin
            logic        r_we;
            logic        r_iv;
            logic [4:0]  r_wr;
            logic [4:0]  r_rs;
            logic [4:0]  r_rt;
            logic [4:0]  r_rd;
            logic [31:0] r_wd;
            logic [31:0] e_rs;
            logic [31:0] e_rt;
            bit          e_rb;
            bit          e_tb;
            bit          e_st;
            bit          hit;
            r_we = ($urandom_range(0, 1) == 1);
            r_iv = ($urandom_range(0, 2) != 0);
            r_wr = 5'($urandom_range(0, 7));
            r_rs = 5'($urandom_range(0, 7));
            r_rt = 5'($urandom_range(0, 7));
            r_rd = 5'($urandom_range(0, 7));
            r_wd = $urandom;
            drive(r_we, r_wr, r_wd, r_rs, r_rt, r_iv, r_rd);

            hit  = r_we && (r_wr != 5'd0);
            e_rs = (r_rs == 5'd0) ? 32'h0 : ((hit && r_wr == r_rs) ? r_wd : m_regs[r_rs]);
            e_rt = (r_rt == 5'd0) ? 32'h0 : ((hit && r_wr == r_rt) ? r_wd : m_regs[r_rt]);
            e_rb = (r_rs != 5'd0) && m_busy[r_rs] && !(hit && r_wr == r_rs);
            e_tb = (r_rt != 5'd0) && m_busy[r_rt] && !(hit && r_wr == r_rt);
            e_st = e_rb || e_tb;
            #2;
            check_all($sformatf("rnd%0d", c), e_rs, e_rt, e_rb, e_tb, e_st);

            if (hit) begin
                m_regs[r_wr] = r_wd;
                m_busy[r_wr] = 1'b0;
            end
            if (r_iv && !e_st && r_rd != 5'd0) begin
                m_busy[r_rd] = 1'b1;
            end
            @(posedge clk);
            #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
